// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types used by the fetch front end.
//   word_t         32-bit machine word
//   fetch_state_t  fetch FSM states (RUN / STOP / HALTED)
//   fetch_entry_t  queued instruction word plus its PC
//   HALT_INSTR     encoding that stops fetch
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STOP   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of fetch_entry_t.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   push, wdata   write wdata at the tail (caller never pushes when full)
//   pop           advance the head (caller never pops when empty)
//   flush         drop all entries; wins over push/pop
//   full, empty   occupancy flags
//   head          entry at the head (contents undefined when empty)
module fetch_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t      mem [DEPTH];
  logic [AW-1:0]     hd, tl;
  logic [CW-1:0]     count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[hd];

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge CLK) begin
    if (push) mem[tl] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else begin
      if (push) tl <= tl + 1'b1;
      if (pop)  hd <= hd + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Owns the fetch PC, requests
// from the icache, buffers {instr, pc} in a fetch_fifo for decode, handles
// redirect flushes and the speculative halt word.
// Optional feature: define FETCH_BYPASS_EN to forward a fetched word straight
// to the decode outputs when the queue is empty.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   imemREN, imemaddr        icache request and fetch PC
//   imemload, ihit           icache returned word and hit
//   redirect, redirect_pc    flush queue and restart fetch at redirect_pc
//   deq                      decode consumes the head entry
//   inst_valid, inst, inst_pc head entry to decode
//   halt                     sticky: halt word left the queue
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0,
  parameter int    DEPTH     = 4,
  parameter word_t HALT_WORD = HALT_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic [31:0] imemload,
  input  logic        ihit,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        halt
);

  fetch_state_t state, state_nxt;
  word_t        fetch_pc;
  fetch_entry_t head_e, cur_e, new_e;
  logic         full, empty;
  logic         redir, enq, byp, deq_ok, push, pop;

  assign imemREN  = (state == RUN) && !full && !RST;
  assign imemaddr = fetch_pc;

  // A redirect after the halt word retired must not restart fetch.
  assign redir = redirect && (state != HALTED);
  assign enq   = imemREN && ihit && !redirect;
  assign new_e = '{instr: imemload, pc: fetch_pc};

`ifdef FETCH_BYPASS_EN
  assign byp = empty && enq;
`else
  assign byp = 1'b0;
`endif

  assign cur_e      = byp ? new_e : head_e;
  assign inst_valid = !empty || byp;
  assign inst       = inst_valid ? cur_e.instr : '0;
  assign inst_pc    = inst_valid ? cur_e.pc    : '0;

  assign deq_ok = deq && inst_valid && (state != HALTED) && !redir;
  // A bypassed word consumed this cycle never enters the queue.
  assign push   = enq && !(byp && deq_ok);
  assign pop    = deq_ok && !empty;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .wdata (new_e),
    .full  (full),
    .empty (empty),
    .head  (head_e)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      fetch_pc <= PC_INIT;
    end else begin
      state <= state_nxt;
      if (redir)    fetch_pc <= redirect_pc;
      else if (enq) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Retiring the halt word outranks enqueuing one (bypass case).
  always_comb begin
    state_nxt = state;
    if (redir) begin
      state_nxt = RUN;
    end else begin
      if (enq && imemload == HALT_WORD)          state_nxt = STOP;
      if (deq_ok && cur_e.instr == HALT_WORD)    state_nxt = HALTED;
    end
  end

  assign halt = (state == HALTED);

endmodule
